fetch_prefetch_queue: RTL
=========================

Name: fetch_prefetch_queue

Overview:
Instruction-fetch front end. It owns the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel with variable response latency. Returned instructions are buffered, paired with their PC, in a small prefetch queue that feeds the fetch/decode pipeline register under a valid/ready stall handshake. Branch/jump redirects arrive from the execute/memory pipeline register; they flush the queue and squash any requests still in flight.

Parameters:
DEPTH, 4, queue entries; also the cap on (queued + in-flight) requests; power of 2, 2..16
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
pc_select_i  in  1  redirect request (from em_pc_select)
pc_branch_i  in  32  redirect target (from em_pc_new); bits [1:0] ignored, treated as 00
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  imem accepts request
imem_addr_o  out  32  fetch word address
imem_rsp_valid_i  in  1  response valid; responses return in request order
imem_rsp_data_i  in  32  instruction word
valid_o  out  1  head entry available to decode
ready_i  in  1  decode accepts head (0 = stall)
instruction_o  out  32  head instruction
pc_o  out  32  head PC
pc_src_o  out  32  head PC + 4

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-high (reset_i). All state updates on the rising edge of clk_i.
- State: fetch_pc, resp_pc, queue count, outstanding counter, discard counter. Counters are clog2(DEPTH+1) bits wide.
- Reset values: fetch_pc = resp_pc = RESET_PC; count, outstanding and discard = 0. While reset_i = 1: imem_req_valid_o = 0 and valid_o = 0.
- Empty-queue outputs: instruction_o = 32'h0000_0013 (NOP), pc_o = 0, pc_src_o = 4.
- Request issue:
  - imem_req_valid_o = (count + outstanding < DEPTH) && !pc_select_i.
  - imem_addr_o = fetch_pc.
  - On fire (valid && ready): fetch_pc += 4, modulo 2^32; outstanding += 1.
  - imem_addr_o is stable while valid is held.
  - valid may drop without a fire only in a redirect cycle.
- Response handling:
  - Each imem_rsp_valid_i decrements outstanding.
  - If discard > 0: decrement discard and drop the data.
  - Otherwise push {resp_pc, data} into the queue and advance resp_pc by 4.
  - A response while outstanding = 0 is a protocol error: ignore it and leave the counters unchanged.
- Credit rule: because issue is limited to count + outstanding < DEPTH, a push never meets a full queue. Push and pop in the same cycle are legal at any occupancy.
- Output:
  - valid_o = (count != 0) && !pc_select_i.
  - Head fields are combinational from the queue head.
  - Pop on valid_o && ready_i.
  - Fetch-to-valid_o latency is 1 cycle after the response cycle (registered push).
- Redirect (pc_select_i = 1):
  - Next cycle: count = 0 and fetch_pc = resp_pc = {pc_branch_i[31:2], 2'b00}.
  - discard = outstanding - imem_rsp_valid_i, so every older in-flight response is squashed.
  - No push, pop or issue occurs in the redirect cycle.
  - First request to the target goes out the following cycle.
  - Back-to-back redirects: the later one wins and discard is recomputed each time.
- Stall: with ready_i = 0, issue continues until the credit limit, then holds. There is no loss and no duplicate.
- Reset mid-operation clears all state. Responses to pre-reset requests are the memory's responsibility; the memory is reset in the same cycle.

Decomposition:
- Shared package fetch_pkg holds: RESET_PC default, NOP_INSTR = 32'h0000_0013, and a typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One natural sub-module, fetch_fifo: a synchronous DEPTH-entry FIFO with push, pop, flush, count and head outputs.
- The top holds the PC, counters, issue and discard logic.

Test Plan:
1. Reset, memory ready every cycle, 1-cycle response latency, DEPTH = 4, ready_i = 1 -> requests at 0x0, 0x4, 0x8, ... on consecutive cycles; decode sees pc_o 0x0, 0x4, ... with pc_src_o = pc_o + 4 and no gaps.
2. ready_i = 0 held for 10 cycles -> exactly 4 requests issued (0x0 to 0xC), count = 4, imem_req_valid_o = 0. Release ready_i -> the 4 entries drain in order, then fetch resumes at 0x10.
3. 3-cycle response latency, then pc_select_i pulse with pc_branch_i = 0x100 while 3 requests are in flight -> those 3 responses are dropped, the queue is empty, the next request is 0x100, and the first valid_o shows pc_o = 0x100.
4. Redirect to 0x203 in the same cycle as a response -> the response is dropped, discard = outstanding - 1, and the next fetch address is 0x200.
5. imem_req_ready_i held low for 5 cycles -> imem_addr_o stays 0x0 throughout, with exactly one fire when ready rises.
6. Reset asserted with 2 entries queued and 2 in flight -> next cycle valid_o = 0, instruction_o = 0x13, and after release the first request is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    parameter logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    parameter logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: redirect input, imem request/response channel, decode handshake.
interface fetch_prefetch_queue_if;

    logic        pc_select_i;
    logic [31:0] pc_branch_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic [31:0] pc_src_o;

    modport master (
        input  pc_select_i, pc_branch_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, ready_i,
        output imem_req_valid_o, imem_addr_o, valid_o, instruction_o, pc_o, pc_src_o
    );

    modport slave (
        output pc_select_i, pc_branch_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, ready_i,
        input  imem_req_valid_o, imem_addr_o, valid_o, instruction_o, pc_o, pc_src_o
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instr} entries with flush and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues credit-limited imem requests, squashes on redirect.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    fetch_prefetch_queue_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [CW:0]   in_use;
    logic [31:0]   target;
    logic          req_valid;
    logic          fire;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic          head_valid;
    fetch_entry_t  head;
    fetch_entry_t  push_data;

    always_comb begin
        in_use     = {1'b0, count} + {1'b0, outstanding};
        target     = {bus.pc_branch_i[31:2], 2'b00};
        req_valid  = !reset_i && (in_use < (CW+1)'(DEPTH)) && !bus.pc_select_i;
        fire       = req_valid && bus.imem_req_ready_i;
        // Responses with nothing outstanding are protocol errors and are ignored.
        rsp_ok     = bus.imem_rsp_valid_i && (outstanding != '0);
        push       = rsp_ok && (discard == '0) && !bus.pc_select_i;
        head_valid = !reset_i && (count != '0) && !bus.pc_select_i;
        pop        = head_valid && bus.ready_i;
        push_data  = '{pc: resp_pc, instr: bus.imem_rsp_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (bus.pc_select_i) begin
            fetch_pc    <= target;
            resp_pc     <= target;
            outstanding <= outstanding - CW'(rsp_ok);
            // Every request still in flight after this cycle belongs to the old path.
            discard     <= outstanding - CW'(rsp_ok);
        end else begin
            if (fire)
                fetch_pc <= fetch_pc + 32'd4;
            if (push)
                resp_pc <= resp_pc + 32'd4;
            outstanding <= outstanding + CW'(fire) - CW'(rsp_ok);
            if (rsp_ok && (discard != '0))
                discard <= discard - CW'(1);
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .flush     (bus.pc_select_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        bus.imem_req_valid_o = req_valid;
        bus.imem_addr_o      = fetch_pc;
        bus.valid_o          = head_valid;
        if (count == '0) begin
            bus.instruction_o = NOP_INSTR;
            bus.pc_o          = 32'h0;
            bus.pc_src_o      = 32'h4;
        end else begin
            bus.instruction_o = head.instr;
            bus.pc_o          = head.pc;
            bus.pc_src_o      = head.pc + 32'd4;
        end
    end

endmodule
